// File: rtl/can_rx_pkg.sv
// Shared constants for the CAN receive path: frame width, ID field position
// and default FIFO sizing.
package can_rx_pkg;
  localparam int CAN_MSG_W    = 128;
  localparam int CAN_ID_MSB   = 127;
  localparam int CAN_ID_LSB   = 115;
  localparam int DEPTH_DEF    = 16;
  localparam int WM_LEVEL_DEF = 12;
endpackage

// File: rtl/can_rx_fifo_mem.sv
// Simple dual-port frame store: synchronous write port, registered read port.
// The read register is the popped-frame output of the FIFO.
module can_rx_fifo_mem
  import can_rx_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [AW-1:0]        waddr_i,
  input  logic [CAN_MSG_W-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [AW-1:0]        raddr_i,
  output logic [CAN_MSG_W-1:0] rdata_o
);

  logic [CAN_MSG_W-1:0] mem_q [DEPTH];
  logic [CAN_MSG_W-1:0] rdata_q;

  // Array kept reset-free so it can map onto RAM primitives.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/can_rx_fifo.sv
// Receive message FIFO between acceptance filter and host interface.
// Optional watermark flag enabled by defining RX_FIFO_WATERMARK_EN.
module can_rx_fifo
  import can_rx_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int WM_LEVEL = WM_LEVEL_DEF
) (
  input  logic                   sys_clk,
  input  logic                   IP2Can_reset,
  input  logic [CAN_MSG_W-1:0]   rxfifo_ip,
  input  logic                   rxfifo_wr,
  input  logic                   rxfifo_rd,
  input  logic                   rxfifo_flush,
  input  logic                   rxfifo_ovfl_clr,
  output logic [CAN_MSG_W-1:0]   rxfifo_op,
  output logic                   rxfifo_op_vld,
  output logic                   rxfifo_empty,
  output logic                   rxfifo_full,
  output logic [$clog2(DEPTH):0] rxfifo_level,
`ifdef RX_FIFO_WATERMARK_EN
  output logic                   rxfifo_wm,
`endif
  output logic                   rxfifo_ovfl
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0)
    $error("can_rx_fifo: DEPTH must be a power of two in 2..64");
  if (WM_LEVEL < 1 || WM_LEVEL > DEPTH)
    $error("can_rx_fifo: WM_LEVEL must be in 1..DEPTH");

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          empty_q, full_q, ovfl_q, ovfl_d, vld_q;
  logic          rd_acc, wr_acc, drop;

  // A read only counts when data exists; a write into a full FIFO is saved
  // only by a read that frees a slot in the same cycle.
  assign rd_acc = rxfifo_rd && !rxfifo_flush && !empty_q;
  assign wr_acc = rxfifo_wr && !rxfifo_flush && (!full_q || rd_acc);
  assign drop   = rxfifo_wr && !rxfifo_flush && full_q && !rd_acc;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovfl_d   = ovfl_q;
    if (rxfifo_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_acc && !rd_acc)      level_d = level_q + LW'(1);
      else if (rd_acc && !wr_acc) level_d = level_q - LW'(1);
    end
    if (drop)                 ovfl_d = 1'b1;
    else if (rxfifo_ovfl_clr) ovfl_d = 1'b0;
  end

  always_ff @(posedge sys_clk or posedge IP2Can_reset) begin
    if (IP2Can_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovfl_q   <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= (level_d == '0);
      full_q   <= (level_d == LW'(DEPTH));
      ovfl_q   <= ovfl_d;
      vld_q    <= rd_acc;
    end
  end

`ifdef RX_FIFO_WATERMARK_EN
  logic wm_q;

  always_ff @(posedge sys_clk or posedge IP2Can_reset) begin
    if (IP2Can_reset) wm_q <= 1'b0;
    else              wm_q <= (level_d >= LW'(WM_LEVEL));
  end

  assign rxfifo_wm = wm_q;
`endif

  can_rx_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk_i   (sys_clk),
    .rst_i   (IP2Can_reset),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (rxfifo_ip),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (rxfifo_op)
  );

  assign rxfifo_op_vld = vld_q;
  assign rxfifo_empty  = empty_q;
  assign rxfifo_full   = full_q;
  assign rxfifo_level  = level_q;
  assign rxfifo_ovfl   = ovfl_q;

endmodule

// File: tb/tb_can_rx_fifo.sv
// Self-checking bench for can_rx_fifo: vector table plus queue model and
// scoreboard; watermark checks compiled in with RX_FIFO_WATERMARK_EN.
module tb_can_rx_fifo;
  localparam int DEPTH    = 16;
  localparam int WM_LEVEL = 12;
  localparam int LW       = $clog2(DEPTH) + 1;

  logic           sys_clk = 1'b0;
  logic           IP2Can_reset;
  logic [127:0]   rxfifo_ip;
  logic           rxfifo_wr, rxfifo_rd, rxfifo_flush, rxfifo_ovfl_clr;
  logic [127:0]   rxfifo_op;
  logic           rxfifo_op_vld, rxfifo_empty, rxfifo_full, rxfifo_ovfl;
  logic [LW-1:0]  rxfifo_level;
`ifdef RX_FIFO_WATERMARK_EN
  logic           rxfifo_wm;
`endif

  can_rx_fifo #(.DEPTH(DEPTH), .WM_LEVEL(WM_LEVEL)) dut (
    .sys_clk         (sys_clk),
    .IP2Can_reset    (IP2Can_reset),
    .rxfifo_ip       (rxfifo_ip),
    .rxfifo_wr       (rxfifo_wr),
    .rxfifo_rd       (rxfifo_rd),
    .rxfifo_flush    (rxfifo_flush),
    .rxfifo_ovfl_clr (rxfifo_ovfl_clr),
    .rxfifo_op       (rxfifo_op),
    .rxfifo_op_vld   (rxfifo_op_vld),
    .rxfifo_empty    (rxfifo_empty),
    .rxfifo_full     (rxfifo_full),
    .rxfifo_level    (rxfifo_level),
`ifdef RX_FIFO_WATERMARK_EN
    .rxfifo_wm       (rxfifo_wm),
`endif
    .rxfifo_ovfl     (rxfifo_ovfl)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic         wr, rd, fl, clr;
    logic [127:0] data;
    int           exp_level;
    logic         exp_empty;
  } vec_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [127:0] mdl[$];
  logic [127:0] exp_q[$];
  logic [127:0] m_op;
  logic         m_ovfl, m_vld;
  vec_t         tbl[16];

  function automatic logic [127:0] fr(input logic [31:0] x);
    return {x, 64'hC0FF_EE00_1234_5678, x};
  endfunction

  function automatic vec_t v(input logic wr, rd, fl, clr, input logic [127:0] d,
                             input int lvl, input logic emp);
    vec_t r;
    r.wr = wr; r.rd = rd; r.fl = fl; r.clr = clr; r.data = d;
    r.exp_level = lvl; r.exp_empty = emp;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input logic wr, rd, fl, clr, input logic [127:0] d);
    int   cnt;
    logic rd_ok, wr_ok, drop;
    @(negedge sys_clk);
    rxfifo_wr = wr; rxfifo_rd = rd; rxfifo_flush = fl; rxfifo_ovfl_clr = clr; rxfifo_ip = d;
    cnt   = mdl.size();
    rd_ok = rd && !fl && cnt != 0;
    wr_ok = wr && !fl && (cnt < DEPTH || rd_ok);
    drop  = wr && !fl && cnt == DEPTH && !rd_ok;
    if (fl) mdl.delete();
    else begin
      if (rd_ok) begin
        m_op = mdl.pop_front();
        exp_q.push_back(m_op);
      end
      if (wr_ok) mdl.push_back(d);
    end
    if (drop)     m_ovfl = 1'b1;
    else if (clr) m_ovfl = 1'b0;
    m_vld = rd_ok;
    @(posedge sys_clk);
    #1;
    chk("vld", 128'(rxfifo_op_vld), 128'(m_vld));
    if (rxfifo_op_vld) begin
      if (exp_q.size() == 0) chk("unexpected_pop", 128'(1), 128'(0));
      else chk("pop_data", rxfifo_op, exp_q.pop_front());
    end
    chk("op_hold", rxfifo_op, m_op);
    chk("level", 128'(rxfifo_level), 128'(mdl.size()));
    chk("empty", 128'(rxfifo_empty), 128'(mdl.size() == 0));
    chk("full", 128'(rxfifo_full), 128'(mdl.size() == DEPTH));
    chk("ovfl", 128'(rxfifo_ovfl), 128'(m_ovfl));
`ifdef RX_FIFO_WATERMARK_EN
    chk("wm", 128'(rxfifo_wm), 128'(mdl.size() >= WM_LEVEL));
`endif
    rxfifo_wr = 0; rxfifo_rd = 0; rxfifo_flush = 0; rxfifo_ovfl_clr = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_op"}, rxfifo_op, 128'(0));
    chk({tag, "_vld"}, 128'(rxfifo_op_vld), 128'(0));
    chk({tag, "_empty"}, 128'(rxfifo_empty), 128'(1));
    chk({tag, "_full"}, 128'(rxfifo_full), 128'(0));
    chk({tag, "_level"}, 128'(rxfifo_level), 128'(0));
    chk({tag, "_ovfl"}, 128'(rxfifo_ovfl), 128'(0));
`ifdef RX_FIFO_WATERMARK_EN
    chk({tag, "_wm"}, 128'(rxfifo_wm), 128'(0));
`endif
  endtask

  initial begin
    tbl[0]  = v(1, 0, 0, 0, fr(32'hA1), 1, 0);
    tbl[1]  = v(1, 0, 0, 0, fr(32'hA2), 2, 0);
    tbl[2]  = v(1, 0, 0, 0, fr(32'hA3), 3, 0);
    tbl[3]  = v(0, 1, 0, 0, '0, 2, 0);
    tbl[4]  = v(0, 1, 0, 0, '0, 1, 0);
    tbl[5]  = v(0, 1, 0, 0, '0, 0, 1);
    tbl[6]  = v(1, 1, 0, 0, fr(32'hB1), 1, 0);
    tbl[7]  = v(0, 1, 0, 0, '0, 0, 1);
    tbl[8]  = v(0, 1, 0, 0, '0, 0, 1);
    tbl[9]  = v(1, 0, 0, 0, fr(32'hC1), 1, 0);
    tbl[10] = v(1, 0, 0, 0, fr(32'hC2), 2, 0);
    tbl[11] = v(1, 0, 0, 0, fr(32'hC3), 3, 0);
    tbl[12] = v(1, 0, 0, 0, fr(32'hC4), 4, 0);
    tbl[13] = v(1, 0, 0, 0, fr(32'hC5), 5, 0);
    tbl[14] = v(1, 0, 1, 0, fr(32'hD0), 0, 1);
    tbl[15] = v(0, 1, 0, 0, '0, 0, 1);

    m_op = '0; m_ovfl = 0; m_vld = 0;
    IP2Can_reset = 1; rxfifo_ip = '0;
    rxfifo_wr = 0; rxfifo_rd = 0; rxfifo_flush = 0; rxfifo_ovfl_clr = 0;
    #12;
    chk_reset_vals("reset");
    @(negedge sys_clk);
    IP2Can_reset = 0;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].fl, tbl[i].clr, tbl[i].data);
      chk($sformatf("tbl%0d_level", i), 128'(rxfifo_level), 128'(tbl[i].exp_level));
      chk($sformatf("tbl%0d_empty", i), 128'(rxfifo_empty), 128'(tbl[i].exp_empty));
    end
    chk("b1_popped", rxfifo_op, fr(32'hB1));

    // 17 writes into 16 entries: the last one is dropped
    for (int i = 1; i <= 17; i++) begin
      step(1, 0, 0, 0, fr(32'h100 + i));
      if (i == 16) chk("full_at_16", 128'(rxfifo_full), 128'(1));
      if (i == 16) chk("no_ovfl_at_16", 128'(rxfifo_ovfl), 128'(0));
    end
    chk("ovfl_at_17", 128'(rxfifo_ovfl), 128'(1));
    chk("level_at_17", 128'(rxfifo_level), 128'(16));
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 0, 0, '0);
      chk($sformatf("ovf_rd%0d", i), rxfifo_op, fr(32'h100 + i));
    end
    chk("ovf_drained", 128'(rxfifo_empty), 128'(1));

    // clear, refill, drop with clear (set wins), then full wr+rd
    step(0, 0, 0, 1, '0);
    chk("ovfl_cleared", 128'(rxfifo_ovfl), 128'(0));
    for (int i = 1; i <= 16; i++) step(1, 0, 0, 0, fr(32'h200 + i));
    step(1, 0, 0, 1, fr(32'h2FF));
    chk("set_wins", 128'(rxfifo_ovfl), 128'(1));
    step(0, 0, 0, 1, '0);
    step(1, 1, 0, 0, fr(32'h2AA));
    chk("full_wr_rd_level", 128'(rxfifo_level), 128'(16));
    chk("full_wr_rd_ovfl", 128'(rxfifo_ovfl), 128'(0));
    chk("full_wr_rd_op", rxfifo_op, fr(32'h201));
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, '0);
    chk("new_frame_last", rxfifo_op, fr(32'h2AA));

`ifdef RX_FIFO_WATERMARK_EN
    for (int i = 1; i <= 12; i++) begin
      step(1, 0, 0, 0, fr(32'h300 + i));
      chk($sformatf("wm_rise%0d", i), 128'(rxfifo_wm), 128'(i >= 12));
    end
    step(0, 1, 0, 0, '0);
    chk("wm_fall", 128'(rxfifo_wm), 128'(0));
    step(0, 0, 1, 0, '0);
`endif

    // asynchronous reset at level 8 with ovfl set and a write in flight
    for (int i = 1; i <= 17; i++) step(1, 0, 0, 0, fr(32'h400 + i));
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, '0);
    chk("pre_rst_level", 128'(rxfifo_level), 128'(8));
    @(negedge sys_clk);
    rxfifo_wr = 1; rxfifo_ip = fr(32'h4FF);
    #2 IP2Can_reset = 1;
    #1 chk_reset_vals("async_rst");
    mdl.delete(); exp_q.delete(); m_op = '0; m_ovfl = 0;
    @(negedge sys_clk);
    IP2Can_reset = 0; rxfifo_wr = 0;
    step(0, 1, 0, 0, '0);
    step(1, 0, 0, 0, fr(32'h501));
    step(0, 1, 0, 0, '0);
    chk("post_rst_pop", rxfifo_op, fr(32'h501));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
